// File: rtl/cv32e40p_fpu_wb_pipe.sv
// FPU writeback-slot scheduler: delays each accepted result by its class latency and
// withholds grant when the new op would collide with an in-flight op on the result bus.
module cv32e40p_fpu_wb_pipe #(
  parameter int unsigned ADDMUL_LAT = 0,
  parameter int unsigned OTHERS_LAT = 0,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             op_class_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             gnt_o,
  input  logic [31:0]      fpu_result_i,
  input  logic [4:0]       fpu_flags_i,
  input  logic             flush_i,
  output logic             rvalid_o,
  output logic [31:0]      result_o,
  output logic [4:0]       flags_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int unsigned MaxLat = (ADDMUL_LAT > OTHERS_LAT) ? ADDMUL_LAT : OTHERS_LAT;
  // One dummy entry when MaxLat is 0; it is never loaded, so it stays invalid.
  localparam int unsigned Depth  = (MaxLat == 0) ? 1 : MaxLat;

  // Entry k holds slot S[k+1]; entry 0 drives the output port.
  logic [Depth-1:0] valid_q, valid_d;
  logic [31:0]      res_q   [Depth];
  logic [31:0]      res_d   [Depth];
  logic [4:0]       flags_q [Depth];
  logic [4:0]       flags_d [Depth];
  logic [TAG_W-1:0] tag_q   [Depth];
  logic [TAG_W-1:0] tag_d   [Depth];

  int unsigned lat;
  logic        slot_busy;
  logic        accept;

  always_comb begin
    lat       = op_class_i ? OTHERS_LAT : ADDMUL_LAT;
    slot_busy = 1'b0;
    // The op would retire one cycle after landing in S[lat], i.e. where S[lat+1] sits now.
    for (int unsigned k = 0; k < MaxLat; k++) begin
      if (k == lat) slot_busy = valid_q[k];
    end
    gnt_o  = !flush_i && !slot_busy;
    accept = req_i && gnt_o;
  end

  always_comb begin
    valid_d = '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      res_d[k]   = '0;
      flags_d[k] = '0;
      tag_d[k]   = '0;
    end
    for (int unsigned k = 0; k + 1 < Depth; k++) begin
      valid_d[k] = valid_q[k+1];
      res_d[k]   = res_q[k+1];
      flags_d[k] = flags_q[k+1];
      tag_d[k]   = tag_q[k+1];
    end
    if (accept && lat != 0) begin
      for (int unsigned k = 0; k < Depth; k++) begin
        if (k + 1 == lat) begin
          valid_d[k] = 1'b1;
          res_d[k]   = fpu_result_i;
          flags_d[k] = fpu_flags_i;
          tag_d[k]   = tag_i;
        end
      end
    end
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < Depth; k++) begin
        res_q[k]   <= '0;
        flags_q[k] <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < Depth; k++) begin
        res_q[k]   <= res_d[k];
        flags_q[k] <= flags_d[k];
        tag_q[k]   <= tag_d[k];
      end
    end
  end

  always_comb begin
    rvalid_o = 1'b0;
    result_o = '0;
    flags_o  = '0;
    tag_o    = '0;
    if (accept && lat == 0) begin
      rvalid_o = 1'b1;
      result_o = fpu_result_i;
      flags_o  = fpu_flags_i;
      tag_o    = tag_i;
    end else if (valid_q[0]) begin
      rvalid_o = 1'b1;
      result_o = res_q[0];
      flags_o  = flags_q[0];
      tag_o    = tag_q[0];
    end
  end

  assign busy_o = |valid_q;

endmodule
